// File: rtl/alu_seq.sv
// alu_seq: sequential MIPS ALU with single-cycle ops, iterative MULTU/DIVU and HI/LO registers.
// Define ALU_SEQ_DIV_EN to build the restoring divider and the DIVU opcode (1101); otherwise 1101 is illegal.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucont,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  // state | meaning
  // IDLE  | waiting for start
  // MUL   | one shift-add step per cycle, counter counts down from WIDTH
  // DIV   | one restoring shift-subtract step per cycle (divider builds only)
  // DONE  | done pulse, outputs valid; start is accepted here as in IDLE

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1110;
  localparam logic [3:0] OP_MFLO  = 4'b1111;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_nxt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign shamt   = b[SW-1:0];
  assign cnt_nxt = cnt - CW'(1);

  always_comb begin
    alu_res = '0;
    case (alucont)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // acc = {partial product, remaining multiplier bits}; add multiplicand then shift right
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]     div_part;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  // acc = {remainder, dividend/quotient}; the top WIDTH+1 bits are the shifted remainder
  assign div_part = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_part - {1'b0, opnd};
  assign div_next = div_diff[WIDTH] ? {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            if (alucont == OP_MULTU) begin
              state <= S_MUL;
              busy  <= 1'b1;
              cnt   <= CNT_LOAD;
              acc   <= {{WIDTH{1'b0}}, b};
              opnd  <= a;
            end
`ifdef ALU_SEQ_DIV_EN
            else if (alucont == OP_DIVU && b == '0) begin
              state  <= S_DONE;
              done   <= 1'b1;
              hi     <= a;
              lo     <= '1;
              result <= '1;
              zero   <= 1'b0;
            end else if (alucont == OP_DIVU) begin
              state <= S_DIV;
              busy  <= 1'b1;
              cnt   <= CNT_LOAD;
              acc   <= {{WIDTH{1'b0}}, a};
              opnd  <= b;
            end
`endif
            else begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= alu_res;
              zero   <= (alu_res == '0);
            end
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt_nxt;
          if (cnt_nxt == '0) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            hi     <= mul_next[2*WIDTH-1:WIDTH];
            lo     <= mul_next[WIDTH-1:0];
            result <= mul_next[WIDTH-1:0];
            zero   <= (mul_next[WIDTH-1:0] == '0);
          end
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt_nxt;
          if (cnt_nxt == '0) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            hi     <= div_next[2*WIDTH-1:WIDTH];
            lo     <= div_next[WIDTH-1:0];
            result <= div_next[WIDTH-1:0];
            zero   <= (div_next[WIDTH-1:0] == '0);
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, handshake/reset sequences and randomized ops against a reference model.
// Divide vectors follow ALU_SEQ_DIV_EN the same way the design does.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, b;
  logic [3:0]   alucont;
  logic         start;
  logic         busy, done, zero;
  logic [W-1:0] result, hi, lo;

  int n_vec = 0;
  int n_bad = 0;

  logic [W-1:0] m_hi, m_lo;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } vec_t;

  vec_t tbl[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .alucont(alucont), .start(start),
    .busy(busy), .done(done), .result(result), .zero(zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] r, input logic [W-1:0] h, input logic [W-1:0] l,
                     input int lat);
    vec_t v;
    v.op = op; v.a = x; v.b = y; v.res = r; v.hi = h; v.lo = l; v.lat = lat;
    tbl.push_back(v);
  endtask

  // Reference: plain arithmetic on the instruction semantics, HI/LO kept in m_hi/m_lo.
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output int lat);
    logic [63:0] p;
    int sh;
    sh  = int'(y[4:0]);
    lat = 1;
    r   = '0;
    case (op)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x + y;
      4'd3:  r = x ^ y;
      4'd4:  r = ~(x | y);
      4'd5:  r = (x < y) ? 32'd1 : 32'd0;
      4'd6:  r = x - y;
      4'd7:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8:  r = x << sh;
      4'd9:  r = x >> sh;
      4'd10: r = x[W-1] ? ~((~x) >> sh) : (x >> sh);
      4'd12: begin
        p = {32'd0, x} * {32'd0, y};
        m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = W + 1;
      end
`ifdef ALU_SEQ_DIV_EN
      4'd13: begin
        if (y == 0) begin
          m_hi = x; m_lo = '1;
        end else begin
          m_hi = x % y; m_lo = x / y; lat = W + 1;
        end
        r = m_lo;
      end
`endif
      4'd14: r = m_hi;
      4'd15: r = m_lo;
      default: r = '0;
    endcase
  endtask

  // Issue one op in cycle C; return latency to done and number of busy cycles seen.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int nbusy, output logic busy_at_done);
    @(negedge clk);
    alucont = op; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    lat = 1; nbusy = 0;
    while (!done && lat < 200) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    busy_at_done = busy;
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] er, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input int elat, input int lat, input int nbusy,
                          input logic bd);
    check({tag, " result"}, 64'(result), 64'(er));
    check({tag, " zero"},   64'(zero),   64'(er == '0));
    check({tag, " hi"},     64'(hi),     64'(eh));
    check({tag, " lo"},     64'(lo),     64'(el));
    check({tag, " latency"}, 64'(lat),   64'(elat));
    check({tag, " busy_cycles"}, 64'(nbusy), 64'(elat - 1));
    check({tag, " busy_with_done"}, 64'(bd), 64'(0));
  endtask

  initial begin
    int lat, nbusy, ndone, first_done, issue_c;
    logic bd, issued;
    logic [W-1:0] er, mul_hi, mul_lo, b2b_res, b2b_done;
    int elat, done_after, busy_pre;

    reset = 1'b1; start = 1'b0; alucont = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset busy",   64'(busy),   64'(0));
    check("reset done",   64'(done),   64'(0));
    check("reset result", 64'(result), 64'(0));
    check("reset zero",   64'(zero),   64'(1));
    check("reset hi",     64'(hi),     64'(0));
    check("reset lo",     64'(lo),     64'(0));
    reset = 1'b0;

    add(4'd6,  32'd5,         32'd7,         32'hFFFF_FFFE, 32'd0, 32'd0, 1);
    add(4'd7,  32'hFFFF_FFFF, 32'd1,         32'd1,         32'd0, 32'd0, 1);
    add(4'd5,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0, 32'd0, 1);
    add(4'd10, 32'h8000_0000, 32'd4,         32'hF800_0000, 32'd0, 32'd0, 1);
    add(4'd8,  32'd3,         32'h21,        32'd6,         32'd0, 32'd0, 1);
    add(4'd2,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0, 32'd0, 1);
    add(4'd0,  32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200, 32'd0, 32'd0, 1);
    add(4'd1,  32'h0000_00F0, 32'h0F00_000F, 32'h0F00_00FF, 32'd0, 32'd0, 1);
    add(4'd3,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 32'd0, 32'd0, 1);
    add(4'd4,  32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000, 32'd0, 32'd0, 1);
    add(4'd9,  32'h8000_0000, 32'h1F,        32'd1,         32'd0, 32'd0, 1);
    add(4'd12, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFE, 33);
    add(4'd14, 32'd0,         32'd0,         32'd1,         32'd1, 32'hFFFF_FFFE, 1);
    add(4'd15, 32'd0,         32'd0,         32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFE, 1);
    add(4'd11, 32'd123,       32'd456,       32'd0,         32'd1, 32'hFFFF_FFFE, 1);
`ifdef ALU_SEQ_DIV_EN
    add(4'd13, 32'd100,       32'd7,         32'd14,        32'd2, 32'd14, 33);
    add(4'd13, 32'd9,         32'd0,         32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFF, 1);
`else
    add(4'd13, 32'd100,       32'd7,         32'd0,         32'd1, 32'hFFFF_FFFE, 1);
`endif

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, nbusy, bd);
      check_op($sformatf("vec%0d", i), tbl[i].res, tbl[i].hi, tbl[i].lo, tbl[i].lat, lat, nbusy, bd);
    end

    // MULTU with a dropped start at C+5, then ADD 1+1 issued in the done cycle
    @(negedge clk);
    alucont = 4'd12; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
    ndone = 0; first_done = 0; issued = 1'b0; issue_c = 0;
    mul_hi = '0; mul_lo = '0; b2b_res = '0; b2b_done = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) begin
        start = 1'b1; alucont = 4'd2; a = 32'd7; b = 32'd8;
      end
      if (issued && c == issue_c + 1) begin
        b2b_res = result; b2b_done = 32'(done);
      end
      if (done) begin
        ndone++;
        if (first_done == 0) begin
          first_done = c; mul_hi = hi; mul_lo = lo;
        end
        if (!issued) begin
          start = 1'b1; alucont = 4'd2; a = 32'd1; b = 32'd1;
          issued = 1'b1; issue_c = c;
        end
      end
    end
    check("hs first_done_cycle", 64'(first_done), 64'(33));
    check("hs done_count",       64'(ndone),      64'(2));
    check("hs mul hi",           64'(mul_hi),     64'(1));
    check("hs mul lo",           64'(mul_lo),     64'(32'hFFFF_FFFE));
    check("hs b2b done",         64'(b2b_done),   64'(1));
    check("hs b2b result",       64'(b2b_res),    64'(2));

    // Reset in cycle C+10 of a MULTU
    @(negedge clk);
    alucont = 4'd12; a = 32'h1234_5678; b = 32'h9ABC_DEF1; start = 1'b1;
    busy_pre = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 9) busy_pre = int'(busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst busy_before", 64'(busy_pre), 64'(1));
    check("rst busy",   64'(busy),   64'(0));
    check("rst done",   64'(done),   64'(0));
    check("rst result", 64'(result), 64'(0));
    check("rst zero",   64'(zero),   64'(1));
    check("rst hi",     64'(hi),     64'(0));
    check("rst lo",     64'(lo),     64'(0));
    done_after = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_after++;
    end
    check("rst no_done_after", 64'(done_after), 64'(0));

    // Randomized ops against the reference model
    m_hi = '0; m_lo = '0;
    for (int i = 0; i < 150; i++) begin
      logic [3:0]   op;
      logic [W-1:0] x, y;
      op = 4'($urandom_range(0, 15));
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      model_op(op, x, y, er, elat);
      run_op(op, x, y, lat, nbusy, bd);
      check_op($sformatf("rnd%0d op%0d a=%0h b=%0h", i, op, x, y), er, m_hi, m_lo, elat, lat, nbusy, bd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the multicycle MIPS datapath. It extends the basic combinational AND/OR/ADD/SUB/SLT unit with:
- a 4-bit operation code, XOR, NOR, unsigned compare and shifts;
- an iterative unsigned multiplier and divider writing HI/LO registers;
- a start/busy/done handshake.

The control FSM issues one operation per `start` pulse. It reads `result` and `zero` while `done` is high.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥ 4, power of two)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt/immediate); low $clog2(WIDTH) bits are the shift amount for shifts
- alucont  in  4  operation code, sampled with `start`
- start  in  1  issue operation; ignored while `busy`=1
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse: `result`/`zero`/`hi`/`lo` valid
- result  out  WIDTH  registered result
- zero  out  1  registered (`result`==0)
- hi  out  WIDTH  HI register (product high / remainder)
- lo  out  WIDTH  LO register (product low / quotient)

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB (a−b), 0111 SLT (signed), 1000 SLL, 1001 SRL, 1010 SRA, 1100 MULTU, 1101 DIVU, 1110 MFHI, 1111 MFLO. Codes 1011 and 1101-without-divider are illegal: `result`=0, `hi`/`lo` unchanged, single-cycle `done`.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
  - SLT/SLTU give 1 or 0, zero-extended.
  - Shift amount is `b[$clog2(WIDTH)-1:0]`; SRA sign-fills from `a[WIDTH-1]`.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: `start` with a single-cycle op → DONE, registering `result`.
  - IDLE: `start` with MULTU → MUL; DIVU → DIV. Operands are latched and the iteration counter is loaded with WIDTH.
  - MUL: one shift-add step per cycle, 2·WIDTH-bit accumulator. When the counter reaches 0 → DONE; then `hi`=product[2W-1:W], `lo`=product[W-1:0], `result`=`lo`.
  - DIV: one restoring shift-subtract step per cycle. When the counter reaches 0 → DONE; then `lo`=quotient, `hi`=remainder, `result`=`lo`.
  - DONE: `done`=1 for exactly one cycle. `start` in this cycle is accepted as if in IDLE; otherwise → IDLE.
- Divide by zero (b=0 at start): no iteration; next state is DONE with `lo`=all ones, `hi`=a.
- MFHI/MFLO return the current `hi`/`lo`. They are single-cycle and never modify HI/LO.
- `result`, `zero`, `hi` and `lo` hold their values until the next operation completes.
- Reset, including mid-operation:
  - state → IDLE; counter is cleared;
  - `busy`=0, `done`=0, `result`=0, `zero`=1, `hi`=0, `lo`=0;
  - any in-flight operation is discarded, with no `done` pulse.

## Timing
- Start cycle is C (`start`=1, `busy`=0 at the rising edge).
- Single-cycle op: `done`=1 and `result` valid in cycle C+1; `busy` never asserts.
- MULTU/DIVU (b≠0): `busy`=1 in cycles C+1..C+WIDTH; `done`=1 in cycle C+WIDTH+1; latency WIDTH+1.
- DIVU with b=0: `done` in C+1; `busy` never asserts.
- Back-to-back: `start` during a `done` cycle issues the next op with no idle bubble.
- `busy` and `done` are never both 1.
- `start` while `busy`=1 is dropped; the operands may change freely during `busy`.

## Configuration
- `ALU_SEQ_DIV_EN` defined:
  - DIV state, divider datapath and DIVU (1101) are present as described.
- Not defined:
  - no DIV state or divider logic is synthesised;
  - 1101 is treated as illegal: `done` in C+1, `result`=0, `hi`/`lo` unchanged;
  - MULTU, MFHI and MFLO behave identically in both builds.

## Test plan
- Reset, then single-cycle ops (WIDTH=32):
  - SUB a=5, b=7 → `result`=0xFFFFFFFE, `zero`=0, `done` in C+1.
  - SLT a=0xFFFFFFFF, b=1 → 1.
  - SLTU with the same operands → 0.
- Shifts: SRA a=0x80000000, b=4 → 0xF8000000. SLL with b=0x21 (amount 1), a=3 → 6.
- MULTU a=0xFFFFFFFF, b=2:
  - `busy` for 32 cycles; `done` in C+33;
  - `hi`=1, `lo`=0xFFFFFFFE;
  - follow with MFHI → 1 and MFLO → 0xFFFFFFFE.
- DIVU (macro on):
  - a=100, b=7 → `lo`=14, `hi`=2 at C+33.
  - a=9, b=0 → `lo`=0xFFFFFFFF, `hi`=9, `done` in C+1.
  - Macro off: 1101 → `result`=0, `hi`/`lo` unchanged.
- Handshake:
  - `start` asserted at C+5 during MULTU is ignored, with no extra `done`.
  - `start` in the `done` cycle runs ADD 1+1 → `result`=2 one cycle later.
- Reset asserted at C+10 of MULTU:
  - next cycle `busy`=0, `hi`=`lo`=`result`=0, `zero`=1;
  - no `done` pulse follows.
